// File: rtl/lfsr_rng.sv
// lfsr_rng: free-running Fibonacci LFSR pseudo-random generator
//   clk  in   1      clock, all state updates on rising edge
//   rst  in   1      synchronous active-high reset, restarts the sequence from SEED
//   out  out  WIDTH  current LFSR state, driven straight from the register
module lfsr_rng #(
    parameter int unsigned WIDTH = 16,
    parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);
    // One maximal-length polynomial per width; bit (n-1) set means term x^n feeds back.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        case (w)
            3:       tap_mask = 32'h0000_0006;
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            9:       tap_mask = 32'h0000_0110;
            10:      tap_mask = 32'h0000_0240;
            11:      tap_mask = 32'h0000_0500;
            12:      tap_mask = 32'h0000_0829;
            13:      tap_mask = 32'h0000_100D;
            14:      tap_mask = 32'h0000_2015;
            15:      tap_mask = 32'h0000_6000;
            16:      tap_mask = 32'h0000_B400;
            17:      tap_mask = 32'h0001_2000;
            18:      tap_mask = 32'h0002_0400;
            19:      tap_mask = 32'h0004_0023;
            20:      tap_mask = 32'h0009_0000;
            21:      tap_mask = 32'h0014_0000;
            22:      tap_mask = 32'h0030_0000;
            23:      tap_mask = 32'h0042_0000;
            24:      tap_mask = 32'h00E1_0000;
            25:      tap_mask = 32'h0120_0000;
            26:      tap_mask = 32'h0200_0023;
            27:      tap_mask = 32'h0400_0013;
            28:      tap_mask = 32'h0900_0000;
            29:      tap_mask = 32'h1400_0000;
            30:      tap_mask = 32'h2000_0029;
            31:      tap_mask = 32'h4800_0000;
            32:      tap_mask = 32'h8020_0003;
            default: tap_mask = 32'h0000_0000;
        endcase
    endfunction

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_rng: unsupported WIDTH %0d (3..32)", WIDTH);
    end

    localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    // A seed that truncates to zero would lock the register, so it becomes 1.
    localparam logic [WIDTH-1:0] RST_VAL  = (SEED[WIDTH-1:0] == '0) ? ONE : SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Zero would shift to zero forever; escape it by loading 1.
    always_comb state_d = rst ? RST_VAL : (state_q == '0) ? ONE : {state_q[WIDTH-2:0], ^(state_q & TAPS)};

    always_ff @(posedge clk) state_q <= state_d;

    assign out = state_q;
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: randomized self-checking bench for lfsr_rng against a polynomial model
module tb_lfsr_rng;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] out16;
    logic [15:0] outz;
    logic [7:0]  out8;
    int          checks = 0;
    int          failures = 0;
    int          m16 = 0;
    int          mz = 0;
    int          m8 = 0;
    int unsigned e16 = 0;
    int unsigned ez = 0;
    int unsigned e8 = 0;
    int          p16[4] = '{16, 14, 13, 11};
    int          p8[4] = '{8, 6, 5, 4};
    bit          seen[65536];

    lfsr_rng u_dut (.clk(clk), .rst(rst), .out(out16));
    lfsr_rng #(.SEED(32'h0)) u_z (.clk(clk), .rst(rst), .out(outz));
    lfsr_rng #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .out(out8));

    always #5 clk = ~clk;

    // Next state from the polynomial exponents: feedback is the parity of the
    // bits at positions (exponent-1), shifted in at the bottom; zero escapes to 1.
    function automatic int unsigned ref_step(input int unsigned s, input int w, input int p[4]);
        int unsigned fb = 0;
        if (s == 0) return 1;
        foreach (p[i]) fb ^= (s >> (p[i] - 1)) & 1;
        return ((s * 2) + fb) % (32'd1 << w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        e16 = rst ? 32'hACE1 : ref_step(e16, 16, p16);
        ez  = rst ? 32'h1    : ref_step(ez, 16, p16);
        e8  = rst ? 32'hE1   : ref_step(e8, 8, p8);
        #1;
        if (32'(out16) !== e16) m16++;
        if (32'(outz) !== ez) mz++;
        if (32'(out8) !== e8) m8++;
    endtask

    initial begin
        int zeros, dups, early, cnt, zero8, early8;
        rst = 1'b1;
        tick();
        tick();
        chk("reset", 32'(out16), 32'hACE1);
        chk("seed0_reset", 32'(outz), 32'h1);
        chk("w8_reset", 32'(out8), 32'hE1);
        rst = 1'b0;
        tick();
        chk("step1", 32'(out16), 32'h59C3);
        chk("seed0_step", 32'(outz), 32'h2);
        tick();
        chk("step2", 32'(out16), 32'hB387);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        zeros = 0; dups = 0; early = 0; cnt = 1; zero8 = 0; early8 = 0;
        seen[16'hACE1] = 1'b1;
        for (int k = 1; k <= 65535; k++) begin
            tick();
            if (k <= 255) begin
                if (out8 == 8'h0) zero8++;
                if (k < 255 && out8 == 8'hE1) early8++;
                if (k == 255) chk("w8_period", 32'(out8), 32'hE1);
            end
            if (k < 65535) begin
                if (out16 == 16'h0) zeros++;
                if (out16 == 16'hACE1) early++;
                if (seen[out16]) dups++;
                else cnt++;
                seen[out16] = 1'b1;
            end
        end
        chk("period_return", 32'(out16), 32'hACE1);
        chk("period_zero", zeros, 0);
        chk("period_early", early, 0);
        chk("period_dup", dups, 0);
        chk("period_count", cnt, 65535);
        chk("w8_zero", zero8, 0);
        chk("w8_early", early8, 0);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 1500)) tick();
            rst = 1'b1;
            tick();
            chk("midrst", 32'(out16), 32'hACE1);
            rst = 1'b0;
            tick();
            chk("midrst_s1", 32'(out16), 32'h59C3);
            tick();
            chk("midrst_s2", 32'(out16), 32'hB387);
        end

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (5) tick();

        @(negedge clk);
        force u_dut.state_q = 16'h0;
        #1 release u_dut.state_q;
        chk("lock_zero", 32'(out16), 32'h0);
        e16 = 0;
        tick();
        chk("lock_one", 32'(out16), 32'h1);
        tick();
        chk("lock_two", 32'(out16), 32'h2);

        rst = 1'b1;
        for (int h = 0; h < 10; h++) begin
            tick();
            chk("rst_hold", 32'(out16), 32'hACE1);
        end
        rst = 1'b0;
        tick();
        chk("rst_release", 32'(out16), 32'h59C3);

        chk("model16", m16, 0);
        chk("model_seed0", mz, 0);
        chk("model_w8", m8, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
